// File: rtl/mod_counter_4bit.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter_4bit
// Brief    : Programmable modulo-N 4-bit up-counter with start/stop, preload,
//            one-cycle rollover pulse and tri-stateable readback outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter_4bit (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic       Enable_In,
  input  logic       Start_Counter_Command_In,
  input  logic       Stop_Counter_Command_In,
  input  logic       Load_Counter_Value_Command_In,
  input  logic [3:0] Preload_Counter_Value_In,
  input  logic [3:0] MOD_Value_In,
  output wire        Counter_Running_Flag_Out,
  output wire        Counter_Rollover_Flag_Out,
  output wire  [3:0] Counter_Count_Out
);

  logic       r_counter_running;
  logic       r_counter_rollover;
  logic [3:0] r_counter_value;

  logic [3:0] w_mod_minus_one;
  logic [3:0] w_load_value;

  // Wraps naturally in 4 bits: MOD=0 yields 15, giving a mod-16 counter.
  assign w_mod_minus_one = MOD_Value_In - 4'd1;
  assign w_load_value    = (Preload_Counter_Value_In > w_mod_minus_one) ?
                           w_mod_minus_one : Preload_Counter_Value_In;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_counter_running <= 1'b0;
    end else if (Start_Counter_Command_In) begin
      r_counter_running <= 1'b1;
    end else if (Stop_Counter_Command_In) begin
      r_counter_running <= 1'b0;
    end
  end

  // Count path looks at the pre-edge running flag, so a Stop still advances once.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_counter_value    <= 4'd0;
      r_counter_rollover <= 1'b0;
    end else if (r_counter_running) begin
      if (r_counter_value >= w_mod_minus_one) begin
        r_counter_value    <= 4'd0;
        r_counter_rollover <= 1'b1;
      end else begin
        r_counter_value    <= r_counter_value + 4'd1;
        r_counter_rollover <= 1'b0;
      end
    end else if (Load_Counter_Value_Command_In) begin
      r_counter_value    <= w_load_value;
      r_counter_rollover <= 1'b0;
    end else begin
      r_counter_rollover <= 1'b0;
    end
  end

  assign Counter_Running_Flag_Out  = Enable_In ? r_counter_running  : 1'bz;
  assign Counter_Rollover_Flag_Out = Enable_In ? r_counter_rollover : 1'bz;
  assign Counter_Count_Out         = Enable_In ? r_counter_value    : 4'bz;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_counter_4bit
// Brief    : Self-checking bench for mod_counter_4bit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_counter_4bit;

  logic       Clk_In = 1'b0;
  logic       Reset_In = 1'b1;
  logic       Enable_In = 1'b1;
  logic       Start_Counter_Command_In = 1'b0;
  logic       Stop_Counter_Command_In = 1'b0;
  logic       Load_Counter_Value_Command_In = 1'b0;
  logic [3:0] Preload_Counter_Value_In = 4'd0;
  logic [3:0] MOD_Value_In = 4'd10;
  wire        Counter_Running_Flag_Out;
  wire        Counter_Rollover_Flag_Out;
  wire  [3:0] Counter_Count_Out;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit m_run  = 1'b0;
  bit m_roll = 1'b0;
  int m_cnt  = 0;

  mod_counter_4bit dut (
    .Clk_In                        (Clk_In),
    .Reset_In                      (Reset_In),
    .Enable_In                     (Enable_In),
    .Start_Counter_Command_In      (Start_Counter_Command_In),
    .Stop_Counter_Command_In       (Stop_Counter_Command_In),
    .Load_Counter_Value_Command_In (Load_Counter_Value_Command_In),
    .Preload_Counter_Value_In      (Preload_Counter_Value_In),
    .MOD_Value_In                  (MOD_Value_In),
    .Counter_Running_Flag_Out      (Counter_Running_Flag_Out),
    .Counter_Rollover_Flag_Out     (Counter_Rollover_Flag_Out),
    .Counter_Count_Out             (Counter_Count_Out)
  );

  always #5 Clk_In = ~Clk_In;

  // One rising edge of the reference behaviour, using the values driven on the inputs.
  task automatic model_edge();
    int n;
    n = (MOD_Value_In == 4'd0) ? 16 : int'(MOD_Value_In);
    if (m_run) begin
      if (m_cnt + 1 >= n) begin
        m_cnt  = 0;
        m_roll = 1'b1;
      end else begin
        m_cnt  = m_cnt + 1;
        m_roll = 1'b0;
      end
    end else begin
      if (Load_Counter_Value_Command_In)
        m_cnt = (int'(Preload_Counter_Value_In) > n - 1) ? n - 1 : int'(Preload_Counter_Value_In);
      m_roll = 1'b0;
    end
    if (Start_Counter_Command_In)     m_run = 1'b1;
    else if (Stop_Counter_Command_In) m_run = 1'b0;
  endtask

  task automatic check(input string tag);
    logic       e_run;
    logic       e_roll;
    logic [3:0] e_cnt;
    e_run  = Enable_In ? m_run  : 1'bz;
    e_roll = Enable_In ? m_roll : 1'bz;
    e_cnt  = Enable_In ? 4'(m_cnt) : 4'bz;
    checks++;
    assert (Counter_Running_Flag_Out === e_run) else begin
      failures++;
      $error("FAIL %s running got=%b exp=%b", tag, Counter_Running_Flag_Out, e_run);
    end
    checks++;
    assert (Counter_Rollover_Flag_Out === e_roll) else begin
      failures++;
      $error("FAIL %s rollover got=%b exp=%b", tag, Counter_Rollover_Flag_Out, e_roll);
    end
    checks++;
    assert (Counter_Count_Out === e_cnt) else begin
      failures++;
      $error("FAIL %s count got=%b exp=%b", tag, Counter_Count_Out, e_cnt);
    end
  endtask

  // Inputs are applied at the falling edge, sampled by the DUT at the rising edge.
  task automatic cycle(input logic st, input logic sp, input logic ld,
                       input logic [3:0] pre, input logic [3:0] md,
                       input logic en, input string tag);
    Start_Counter_Command_In      = st;
    Stop_Counter_Command_In       = sp;
    Load_Counter_Value_Command_In = ld;
    Preload_Counter_Value_In      = pre;
    MOD_Value_In                  = md;
    Enable_In                     = en;
    @(posedge Clk_In);
    model_edge();
    @(negedge Clk_In);
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 Reset_In = 1'b1;
    m_run = 1'b0; m_roll = 1'b0; m_cnt = 0;
    #1 check(tag);
    @(negedge Clk_In);
    Reset_In = 1'b0;
    check({tag, "_rel"});
  endtask

  initial begin
    // Reset state
    Start_Counter_Command_In = 1'b0;
    @(negedge Clk_In);
    check("reset");
    Reset_In = 1'b0;
    @(negedge Clk_In);
    check("post_reset");

    // Enable toggling while idle
    cycle(0, 0, 0, 4'd0, 4'd10, 0, "en_off");
    cycle(0, 0, 0, 4'd0, 4'd10, 1, "en_on");

    // Modulus of 10: run for 15 cycles, then stop
    cycle(1, 0, 0, 4'd0, 4'd10, 1, "start10");
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 4'd0, 4'd10, 1, "run10");
    cycle(0, 1, 0, 4'd0, 4'd10, 1, "stop10");
    cycle(0, 0, 0, 4'd0, 4'd10, 1, "frozen");
    cycle(0, 0, 1, 4'd3, 4'd10, 1, "load_idle");

    // Preload 5 then count through the wrap
    do_reset("reset2");
    cycle(0, 0, 1, 4'd5, 4'd10, 1, "load5");
    cycle(1, 0, 0, 4'd0, 4'd10, 1, "start5");
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 4'd2, 4'd10, 1, "run5_ld_ignored");
    cycle(0, 1, 0, 4'd0, 4'd10, 1, "stop5");

    // Clamped preload
    cycle(0, 0, 1, 4'd15, 4'd10, 1, "clamp");
    checks++;
    assert (Counter_Count_Out === 4'd9) else begin
      failures++;
      $error("FAIL clamp_const count got=%b exp=%b", Counter_Count_Out, 4'd9);
    end
    cycle(1, 0, 0, 4'd0, 4'd10, 1, "start_clamp");
    cycle(0, 0, 0, 4'd0, 4'd10, 1, "wrap_clamp");

    // Outputs disabled while running, then Start+Stop together
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'd0, 4'd10, 0, "hidden");
    cycle(0, 0, 0, 4'd0, 4'd10, 1, "reveal");
    cycle(1, 1, 0, 4'd0, 4'd10, 1, "start_stop");

    // Boundary moduli: MOD=1, MOD=0, MOD lowered below count
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'd0, 4'd1, 1, "mod1");
    for (int i = 0; i < 18; i++) cycle(0, 0, 0, 4'd0, 4'd0, 1, "mod16");
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 4'd0, 4'd15, 1, "mod15");
    cycle(0, 0, 0, 4'd0, 4'd4, 1, "mod_lowered");
    cycle(0, 0, 0, 4'd0, 4'd4, 1, "mod_lowered2");

    // Reset mid-count
    do_reset("reset_mid");
    cycle(0, 0, 0, 4'd0, 4'd10, 1, "no_restart");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] md;
      md = (($urandom % 8) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 15));
      if (($urandom % 60) == 0) do_reset("rnd_reset");
      cycle(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
            4'($urandom), md, ($urandom % 10) != 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
